coin_order_collector: RTL and testbench

- Front-end stage directly upstream of the vending-machine core (lab3_2).
- Accumulates inserted coins into a 6-bit credit and latches product/machine/sugar selection.
- On confirm, presents one stable order to the core with a one-cycle strobe, waits for the core's verdict, then emits the change to the coin-return unit.
- Handles cancel, over-credit coin rejection and a no-response timeout.

---
 rtl/lab3_pkg.sv | 30 +++
 rtl/coin_credit_accumulator.sv | 53 +++++
 rtl/coin_order_collector.sv | 179 +++++++++++++++++
 tb/tb_coin_order_collector.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lab3_pkg.sv
// Shared types and coin decoding for the order-collector front end of the vending core.
// Pure declarations; no timing or flow-control behaviour of its own.
package lab3_pkg;

   localparam int MONEY_W = 6;
   localparam int PID_W   = 3;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      ISSUE,
      WAIT,
      REFUND
   } state_t;

   localparam logic [1:0] COIN_1  = 2'b00;
   localparam logic [1:0] COIN_5  = 2'b01;
   localparam logic [1:0] COIN_10 = 2'b10;
   localparam logic [1:0] COIN_20 = 2'b11;

   function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] code);
      case (code)
         COIN_1:  coin_value = 6'd1;
         COIN_5:  coin_value = 6'd5;
         COIN_10: coin_value = 6'd10;
         default: coin_value = 6'd20;
      endcase
   endfunction

endpackage

// File: rtl/coin_credit_accumulator.sv
// Credit register: adds decoded coins while accept_en, rejects overflow past MAX_CREDIT.
// One-cycle latency; a rejected coin leaves credit unchanged and pulses coin_reject next cycle.
module coin_credit_accumulator
   import lab3_pkg::*;
#(
   parameter int MAX_CREDIT = 63
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               coin_vld,
   input  logic [1:0]         coin_code,
   input  logic               accept_en,
   input  logic               clear,
   output logic [MONEY_W-1:0] credit,
   output logic [MONEY_W-1:0] credit_nxt,
   output logic               coin_acc,
   output logic               coin_reject
);

   localparam logic [MONEY_W:0] MAX_SUM = MAX_CREDIT[MONEY_W:0];

   logic [MONEY_W-1:0] credit_q, credit_d;
   logic               coin_reject_q, coin_reject_d;
   logic [MONEY_W:0]   sum;

   // Sum is one bit wider so an overflowing coin is detected rather than wrapped.
   always_comb begin
      sum           = {1'b0, credit_q} + {1'b0, coin_value(coin_code)};
      coin_acc      = coin_vld && accept_en && (sum <= MAX_SUM);
      coin_reject_d = coin_vld && !coin_acc;
      credit_d      = credit_q;
      if (clear) begin
         credit_d = '0;
      end else if (coin_acc) begin
         credit_d = sum[MONEY_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         credit_q      <= '0;
         coin_reject_q <= 1'b0;
      end else begin
         credit_q      <= credit_d;
         coin_reject_q <= coin_reject_d;
      end
   end

   assign credit      = credit_q;
   assign credit_nxt  = credit_d;
   assign coin_reject = coin_reject_q;

endmodule

// File: rtl/coin_order_collector.sv
// Collects coins and a selection, issues one order strobe to the core, then returns change.
// Orders appear one cycle after confirm; the core is never backpressured, a missing verdict forces a refund.
module coin_order_collector
   import lab3_pkg::*;
#(
   parameter int MAX_CREDIT   = 63,
   parameter int WAIT_TIMEOUT = 8
) (
   input  logic               CLK,
   input  logic               resetN,
   input  logic               coinValid,
   input  logic [1:0]         coinCode,
   input  logic               selectValid,
   input  logic [PID_W-1:0]   selProduct,
   input  logic               selVm,
   input  logic               selSugar,
   input  logic               confirm,
   input  logic               cancel,
   input  logic               productReady,
   input  logic               coreError,
   input  logic [MONEY_W-1:0] moneyLeft,
   output logic [MONEY_W-1:0] money,
   output logic               vm,
   output logic [PID_W-1:0]   productID,
   output logic               sugar,
   output logic               orderValid,
   output logic [MONEY_W-1:0] changeOut,
   output logic               changeValid,
   output logic               coinReject,
   output logic               timeoutErr,
   output logic               busy
);

   localparam int               CNT_W    = $clog2(WAIT_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

   state_t             state_q, state_d;
   logic               selected_q, selected_d;
   logic               vm_q, vm_d;
   logic [PID_W-1:0]   pid_q, pid_d;
   logic               sugar_q, sugar_d;
   logic               order_valid_q, order_valid_d;
   logic [MONEY_W-1:0] change_out_q, change_out_d;
   logic               change_valid_q, change_valid_d;
   logic               timeout_err_q, timeout_err_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [MONEY_W-1:0] credit, credit_nxt;
   logic               coin_acc, coin_reject;
   logic               open_q;

   assign open_q = (state_q == IDLE) || (state_q == COLLECT);

   coin_credit_accumulator #(
      .MAX_CREDIT(MAX_CREDIT)
   ) u_credit (
      .clk        (CLK),
      .rst_n      (resetN),
      .coin_vld   (coinValid),
      .coin_code  (coinCode),
      .accept_en  (open_q),
      .clear      (state_q == REFUND),
      .credit     (credit),
      .credit_nxt (credit_nxt),
      .coin_acc   (coin_acc),
      .coin_reject(coin_reject)
   );

   always_comb begin
      state_d        = state_q;
      selected_d     = selected_q;
      vm_d           = vm_q;
      pid_d          = pid_q;
      sugar_d        = sugar_q;
      change_out_d   = change_out_q;
      cnt_d          = cnt_q;
      order_valid_d  = 1'b0;
      change_valid_d = 1'b0;
      timeout_err_d  = 1'b0;

      // Selection is frozen from ISSUE onward so the core sees a stable order.
      if (selectValid && open_q) begin
         selected_d = 1'b1;
         vm_d       = selVm;
         pid_d      = selProduct;
         sugar_d    = selSugar;
      end

      case (state_q)
         IDLE: begin
            if (coin_acc) state_d = COLLECT;
         end
         COLLECT: begin
            // A coin landing with cancel is refunded along with the rest.
            if (cancel) begin
               state_d        = REFUND;
               change_out_d   = credit_nxt;
               change_valid_d = 1'b1;
            end else if (confirm && selected_q) begin
               state_d       = ISSUE;
               order_valid_d = 1'b1;
            end
         end
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = '0;
         end
         WAIT: begin
            if (productReady) begin
               state_d        = REFUND;
               change_out_d   = (moneyLeft < credit) ? moneyLeft : credit;
               change_valid_d = 1'b1;
            end else if (coreError) begin
               state_d        = REFUND;
               change_out_d   = credit;
               change_valid_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d        = REFUND;
               change_out_d   = credit;
               change_valid_d = 1'b1;
               timeout_err_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         REFUND: begin
            state_d    = IDLE;
            selected_d = 1'b0;
            vm_d       = 1'b0;
            pid_d      = '0;
            sugar_d    = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == ISSUE) || (state_d == WAIT) || (state_d == REFUND);
   end

   always_ff @(posedge CLK) begin
      if (!resetN) begin
         state_q        <= IDLE;
         selected_q     <= 1'b0;
         vm_q           <= 1'b0;
         pid_q          <= '0;
         sugar_q        <= 1'b0;
         order_valid_q  <= 1'b0;
         change_out_q   <= '0;
         change_valid_q <= 1'b0;
         timeout_err_q  <= 1'b0;
         busy_q         <= 1'b0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         selected_q     <= selected_d;
         vm_q           <= vm_d;
         pid_q          <= pid_d;
         sugar_q        <= sugar_d;
         order_valid_q  <= order_valid_d;
         change_out_q   <= change_out_d;
         change_valid_q <= change_valid_d;
         timeout_err_q  <= timeout_err_d;
         busy_q         <= busy_d;
         cnt_q          <= cnt_d;
      end
   end

   assign money       = credit;
   assign vm          = vm_q;
   assign productID   = pid_q;
   assign sugar       = sugar_q;
   assign orderValid  = order_valid_q;
   assign changeOut   = change_out_q;
   assign changeValid = change_valid_q;
   assign coinReject  = coin_reject;
   assign timeoutErr  = timeout_err_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_coin_order_collector.sv
// Directed bench for coin_order_collector with order/change scoreboards.
module tb_coin_order_collector;
   import lab3_pkg::*;

   logic       CLK = 1'b0;
   logic       resetN = 1'b0;
   logic       coinValid = 1'b0;
   logic [1:0] coinCode = 2'b00;
   logic       selectValid = 1'b0;
   logic [2:0] selProduct = 3'd0;
   logic       selVm = 1'b0;
   logic       selSugar = 1'b0;
   logic       confirm = 1'b0;
   logic       cancel = 1'b0;
   logic       productReady = 1'b0;
   logic       coreError = 1'b0;
   logic [5:0] moneyLeft = 6'd0;
   logic [5:0] money;
   logic       vm;
   logic [2:0] productID;
   logic       sugar;
   logic       orderValid;
   logic [5:0] changeOut;
   logic       changeValid;
   logic       coinReject;
   logic       timeoutErr;
   logic       busy;

   int errors = 0;
   int checks = 0;

   logic [10:0] ord_q[$];
   logic [5:0]  chg_q[$];

   coin_order_collector #(.MAX_CREDIT(63), .WAIT_TIMEOUT(8)) dut (
      .CLK(CLK), .resetN(resetN), .coinValid(coinValid), .coinCode(coinCode),
      .selectValid(selectValid), .selProduct(selProduct), .selVm(selVm),
      .selSugar(selSugar), .confirm(confirm), .cancel(cancel),
      .productReady(productReady), .coreError(coreError), .moneyLeft(moneyLeft),
      .money(money), .vm(vm), .productID(productID), .sugar(sugar),
      .orderValid(orderValid), .changeOut(changeOut), .changeValid(changeValid),
      .coinReject(coinReject), .timeoutErr(timeoutErr), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every order strobe and change strobe must match a queued expectation.
   always @(negedge CLK) begin
      if (orderValid === 1'b1) begin
         if (ord_q.size() == 0) chk("spurious_orderValid", 32'(orderValid), 32'd0);
         else chk("order_fields", 32'({vm, sugar, productID, money}), 32'(ord_q.pop_front()));
      end
      if (changeValid === 1'b1) begin
         if (chg_q.size() == 0) chk("spurious_changeValid", 32'(changeValid), 32'd0);
         else chk("change_amount", 32'(changeOut), 32'(chg_q.pop_front()));
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic coin(input logic [1:0] code);
      coinValid = 1'b1;
      coinCode  = code;
      cyc();
      coinValid = 1'b0;
   endtask

   task automatic select(input logic [2:0] pid, input logic v, input logic s);
      selectValid = 1'b1;
      selProduct  = pid;
      selVm       = v;
      selSugar    = s;
      cyc();
      selectValid = 1'b0;
   endtask

   // Select, confirm, and step into WAIT; the expected order is queued before the strobe.
   task automatic do_order(input logic [2:0] pid, input logic [5:0] exp_money);
      select(pid, 1'b1, 1'b1);
      ord_q.push_back({1'b1, 1'b1, pid, exp_money});
      confirm = 1'b1;
      cyc();
      confirm = 1'b0;
      chk("issue_orderValid", 32'(orderValid), 32'd1);
      cyc();
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_orderValid_low", 32'(orderValid), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_outputs"}, 32'({money, vm, productID, sugar, orderValid, changeOut,
                                   changeValid, coinReject, timeoutErr, busy}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc();
      cyc();
      check_all_zero("reset");
      resetN = 1'b1;

      // Normal purchase with partial change.
      coin(COIN_20); coin(COIN_20); coin(COIN_10);
      chk("credit_50", 32'(money), 32'd50);
      do_order(3'd3, 6'd50);
      chg_q.push_back(6'd12);
      productReady = 1'b1; moneyLeft = 6'd12;
      cyc();
      productReady = 1'b0;
      chk("served_changeValid", 32'(changeValid), 32'd1);
      chk("served_changeOut", 32'(changeOut), 32'd12);
      cyc();
      chk("after_refund_money", 32'(money), 32'd0);
      chk("after_refund_busy", 32'(busy), 32'd0);
      chk("changeOut_holds", 32'(changeOut), 32'd12);
      chk("changeValid_one_cycle", 32'(changeValid), 32'd0);

      // Over-credit rejection and the exact-63 boundary.
      coin(COIN_20); coin(COIN_20); coin(COIN_10);
      coin(COIN_20);
      chk("reject_pulse", 32'(coinReject), 32'd1);
      chk("reject_money_kept", 32'(money), 32'd50);
      coin(COIN_10);
      chk("reject_pulse_clears", 32'(coinReject), 32'd0);
      chk("credit_60", 32'(money), 32'd60);
      coin(COIN_5);
      chk("reject_65", 32'(coinReject), 32'd1);
      coin(COIN_1); coin(COIN_1); coin(COIN_1);
      chk("credit_63_accepted", 32'(money), 32'd63);
      chk("credit_63_no_reject", 32'(coinReject), 32'd0);
      chg_q.push_back(6'd63);
      cancel = 1'b1; cyc(); cancel = 1'b0;
      chk("cancel63_changeValid", 32'(changeValid), 32'd1);
      cyc();

      // Confirm without a selection is ignored; cancel refunds.
      coin(COIN_5);
      confirm = 1'b1; cyc(); confirm = 1'b0;
      chk("noselect_orderValid", 32'(orderValid), 32'd0);
      chk("noselect_busy", 32'(busy), 32'd0);
      chg_q.push_back(6'd5);
      cancel = 1'b1; cyc(); cancel = 1'b0;
      chk("cancel5_changeOut", 32'(changeOut), 32'd5);
      cyc();

      // Cancel and confirm together: cancel wins.
      coin(COIN_10);
      select(3'd5, 1'b0, 1'b0);
      chg_q.push_back(6'd10);
      cancel = 1'b1; confirm = 1'b1; cyc(); cancel = 1'b0; confirm = 1'b0;
      chk("cancel_wins_orderValid", 32'(orderValid), 32'd0);
      chk("cancel_wins_changeValid", 32'(changeValid), 32'd1);
      cyc();

      // Coin in the confirm cycle is included; change clamps to credit.
      coin(COIN_10);
      select(3'd2, 1'b0, 1'b1);
      ord_q.push_back({1'b0, 1'b1, 3'd2, 6'd15});
      coinValid = 1'b1; coinCode = COIN_5; confirm = 1'b1;
      cyc();
      coinValid = 1'b0; confirm = 1'b0;
      chk("coin_confirm_money", 32'(money), 32'd15);
      cyc();
      chg_q.push_back(6'd15);
      productReady = 1'b1; coreError = 1'b1; moneyLeft = 6'd40;
      cyc();
      productReady = 1'b0; coreError = 1'b0;
      chk("clamp_changeOut", 32'(changeOut), 32'd15);
      cyc();

      // Core error gives a full refund; cancel and coins are refused in WAIT.
      coin(COIN_20); coin(COIN_10);
      do_order(3'd1, 6'd30);
      cancel = 1'b1; cyc(); cancel = 1'b0;
      chk("wait_cancel_ignored", 32'(changeValid), 32'd0);
      coin(COIN_1);
      chk("wait_coin_reject", 32'(coinReject), 32'd1);
      chk("wait_coin_money", 32'(money), 32'd30);
      chg_q.push_back(6'd30);
      coreError = 1'b1; cyc(); coreError = 1'b0;
      chk("error_changeOut", 32'(changeOut), 32'd30);
      chk("error_no_timeout", 32'(timeoutErr), 32'd0);
      cyc();

      // Timeout after exactly WAIT_TIMEOUT cycles in WAIT.
      coin(COIN_10); coin(COIN_5);
      do_order(3'd4, 6'd15);
      for (int k = 1; k < 8; k++) begin
         cyc();
         chk("timeout_early_change", 32'(changeValid), 32'd0);
         chk("timeout_early_err", 32'(timeoutErr), 32'd0);
      end
      chg_q.push_back(6'd15);
      cyc();
      chk("timeout_err", 32'(timeoutErr), 32'd1);
      chk("timeout_changeValid", 32'(changeValid), 32'd1);
      chk("timeout_changeOut", 32'(changeOut), 32'd15);
      cyc();
      chk("timeout_err_pulse", 32'(timeoutErr), 32'd0);

      // Reset mid-order discards credit without change.
      coin(COIN_20); coin(COIN_5);
      do_order(3'd6, 6'd25);
      resetN = 1'b0; cyc(); resetN = 1'b1;
      check_all_zero("midreset");
      cyc();
      chk("midreset_quiet", 32'(changeValid), 32'd0);
      coin(COIN_1);
      chk("post_reset_money", 32'(money), 32'd1);
      chg_q.push_back(6'd1);
      cancel = 1'b1; cyc(); cancel = 1'b0;
      cyc(); cyc();

      chk("order_queue_drained", 32'(ord_q.size()), 32'd0);
      chk("change_queue_drained", 32'(chg_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
